// File: rtl/jpipeadder.sv
// jpipeadder: slice-pipelined adder/subtractor with valid/ready flow control.
// WIDTH-bit operands are added SW=WIDTH/STAGES bits per stage, with each stage's carry registered.
// Ports: clk, reset (async, active-high); in_valid/in_ready with A, B, carryin, sub;
//        out_valid/out_ready with Y, carryout; ovf only when JPIPEADDER_OVF_EN is defined.
module jpipeadder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carryin,
    input  logic             sub,
    output logic [WIDTH-1:0] Y,
    output logic             carryout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef JPIPEADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("jpipeadder: WIDTH must be >=2 and a multiple of STAGES");
    end

    logic [STAGES-1:0] v_d, v_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic              in_ready_c;

    // Walk from the output back to stage 0. "room" is true when everything
    // downstream of the current stage can take one more token this cycle,
    // so a stage advances iff it holds a token and there is room after it.
    always_comb begin : ctrl
        logic room;
        room = out_ready;
        adv  = '0;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = v_q[k] & room;
            room   = room | ~v_q[k];
        end
        in_ready_c = room;

        load    = '0;
        load[0] = in_valid & in_ready_c;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = load[k] | (v_q[k] & ~adv[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    // Stage k keeps the finished low result bits [YW-1:0] and the operand
    // bits still to be added, shifted down so the next slice is always
    // at bit 0. The last stage has no operands left to carry forward.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int OW = WIDTH - k * SW;
        localparam int YW = (k + 1) * SW;

        logic [OW-1:0] a_in;
        logic [OW-1:0] b_in;
        logic          c_in;
        logic [SW:0]   sum;
        logic [YW-1:0] y_new;
        logic [YW-1:0] y_d, y_q;
        logic          c_d, c_q;

        if (k == 0) begin : g_src
            always_comb begin
                a_in  = A;
                b_in  = sub ? ~B : B;
                // Subtract forces the +1 of the two's complement.
                c_in  = sub | carryin;
                y_new = sum[SW-1:0];
            end
        end else begin : g_src
            always_comb begin
                a_in  = g_st[k-1].g_op.a_q;
                b_in  = g_st[k-1].g_op.b_q;
                c_in  = g_st[k-1].c_q;
                y_new = {sum[SW-1:0], g_st[k-1].y_q};
            end
        end

        always_comb begin
            sum = {1'b0, a_in[SW-1:0]}
                + {1'b0, b_in[SW-1:0]}
                + {{SW{1'b0}}, c_in};
            y_d = load[k] ? y_new  : y_q;
            c_d = load[k] ? sum[SW] : c_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                y_q <= '0;
                c_q <= 1'b0;
            end else begin
                y_q <= y_d;
                c_q <= c_d;
            end
        end

        if (k < LAST) begin : g_op
            logic [OW-SW-1:0] a_d, a_q;
            logic [OW-SW-1:0] b_d, b_q;

            always_comb begin
                a_d = load[k] ? a_in[OW-1:SW] : a_q;
                b_d = load[k] ? b_in[OW-1:SW] : b_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

`ifdef JPIPEADDER_OVF_EN
        if (k == LAST) begin : g_ovf
            logic ovf_new;
            logic ovf_d, ovf_q;

            // Same-sign operands giving an opposite-sign result; this is
            // equivalent to carry-into-MSB XOR carry-out.
            always_comb begin
                ovf_new = (a_in[OW-1] == b_in[OW-1])
                        && (sum[SW-1] != a_in[OW-1]);
                ovf_d   = load[k] ? ovf_new : ovf_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif
    end

    assign in_ready  = in_ready_c;
    assign out_valid = v_q[LAST];
    assign Y         = g_st[LAST].y_q;
    assign carryout  = g_st[LAST].c_q;
`ifdef JPIPEADDER_OVF_EN
    assign ovf       = g_st[LAST].g_ovf.ovf_q;
`endif

endmodule
